// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding and PC step.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      ERROR = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive FETCH cycles without an ack; flags expiry on the
// cycle that would complete TIMEOUT_CYC unanswered cycles.
module fetch_timeout_ctr #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)      cnt_d = 8'd0;
      else if (count_i) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i) cnt_q <= cnt_d;

   // Expiry is reported in the last unanswered cycle so the FSM can move
   // to ERROR on the following edge.
   assign expired_o = count_i && !clear_i && (cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/VALID/ERROR sequencer with memory timeout.
// Optional retired-fetch counter enabled by defining FETCH_PERF_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
`ifdef FETCH_PERF_EN
  ,output logic [31:0] fetch_count
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic         err_q, err_d;
   logic         in_fetch, expired;

   assign in_fetch = (state_q == FETCH);

   fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk_i    (clk),
      .clear_i  (rst || redirect_valid || imem_ack || !in_fetch),
      .count_i  (in_fetch),
      .expired_o(expired)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] cnt_q, cnt_d;
   assign cnt_d = (state_q == VALID && state_d == FETCH) ? cnt_q + 32'd1 : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 32'd0;
      else     cnt_q <= cnt_d;
   end
   assign fetch_count = cnt_q;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      err_d    = err_q;
      // Redirect wins over everything but reset; same-cycle ack data is lost.
      if (redirect_valid) begin
         pc_d    = redirect_pc & ~32'd3;
         state_d = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack) begin
                  instr_d  = imem_rdata;
                  pc_out_d = pc_q;
                  pc_d     = pc_q + PC_INCR;
                  state_d  = VALID;
               end else if (expired) begin
                  err_d   = 1'b1;
                  state_d = ERROR;
               end
            end
            VALID:   if (!stall) state_d = FETCH;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= 32'd0;
         pc_out_q <= RESET_PC;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         err_q    <= err_d;
      end
   end

   assign imem_req    = in_fetch && !rst;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state_q == VALID);
   assign pc_out      = pc_out_q;
   assign pc_plus4    = pc_out_q + PC_INCR;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cadence, stall, redirect, timeout, wrap, reset.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid, imem_ack;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, instr_valid, fetch_err;
   logic [31:0] imem_addr, instr, pc_out, pc_plus4;
   logic        w_req, w_valid, w_err;
   logic [31:0] w_addr, w_instr, w_pc_out, w_plus4;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count, w_count;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_fetch u_dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
`ifdef FETCH_PERF_EN
     ,.fetch_count(fetch_count)
`endif
   );

   // Second instance exercises the top-of-address-space wrap from reset.
   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(w_instr), .instr_valid(w_valid),
      .pc_out(w_pc_out), .pc_plus4(w_plus4), .fetch_err(w_err)
`ifdef FETCH_PERF_EN
     ,.fetch_count(w_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      tick(); tick();

      // Reset state, request suppressed while rst is high
      chk("rst_req",   32'(imem_req),    32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pcout", pc_out,           32'd0);
      chk("rst_instr", instr,            32'd0);
      chk("rst_err",   32'(fetch_err),   32'd0);
      chk("rst_wpc",   w_pc_out,         32'hFFFF_FFFC);
      rst = 1'b0;
      #1;
      chk("first_req",  32'(imem_req), 32'd1);
      chk("first_addr", imem_addr,     32'd0);
      chk("w_addr0",    w_addr,        32'hFFFF_FFFC);

      // Back-to-back fetches, ack level held high (ignored while VALID)
      imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
      tick();
      chk("f0_valid", 32'(instr_valid), 32'd1);
      chk("f0_req",   32'(imem_req),    32'd0);
      chk("f0_instr", instr,            32'h2001_0005);
      chk("f0_pc",    pc_out,           32'd0);
      chk("f0_pc4",   pc_plus4,         32'd4);
      chk("w_pcout",  w_pc_out,         32'hFFFF_FFFC);
      chk("w_pc4",    w_plus4,          32'd0);
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("f1_valid0", 32'(instr_valid), 32'd0);
      chk("f1_addr",   imem_addr,        32'd4);
      chk("ack_ign",   instr,            32'h2001_0005);
      chk("w_addr1",   w_addr,           32'd0);
      imem_rdata = 32'h2001_0005;
      tick();
      chk("f1_valid", 32'(instr_valid), 32'd1);
      chk("f1_pc",    pc_out,           32'd4);
      chk("f1_pc4",   pc_plus4,         32'd8);
      tick();
      chk("f2_addr", imem_addr, 32'd8);
      tick();
      chk("f2_valid", 32'(instr_valid), 32'd1);
      chk("f2_pc",    pc_out,           32'd8);
      chk("f2_pc4",   pc_plus4,         32'd12);
      imem_ack = 1'b0;

      // Stall holds VALID for three extra cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stl_valid", 32'(instr_valid), 32'd1);
         chk("stl_req",   32'(imem_req),    32'd0);
         chk("stl_pc",    pc_out,           32'd8);
         chk("stl_instr", instr,            32'h2001_0005);
      end
      stall = 1'b0;
      tick();
      chk("stl_exit_req",  32'(imem_req), 32'd1);
      chk("stl_exit_addr", imem_addr,     32'd12);

      // Redirect with same-cycle ack: data dropped, target aligned
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
      imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      tick();
      redirect_valid = 1'b0; imem_ack = 1'b0;
      #1;
      chk("rd_valid", 32'(instr_valid), 32'd0);
      chk("rd_addr",  imem_addr,        32'h40);
      chk("rd_instr", instr,            32'h2001_0005);
      imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001;
      tick();
      imem_ack = 1'b0;
      chk("rd_pc",    pc_out, 32'h40);
      chk("rd_data",  instr,  32'hA5A5_0001);

      // 15 unanswered cycles then an ack: no timeout
      tick();
      for (int i = 0; i < 15; i++) begin
         chk("nto_req", 32'(imem_req), 32'd1);
         tick();
      end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0777;
      tick();
      imem_ack = 1'b0;
      chk("nto_valid", 32'(instr_valid), 32'd1);
      chk("nto_pc",    pc_out,           32'h44);
      chk("nto_err",   32'(fetch_err),   32'd0);

      // 16 unanswered cycles -> ERROR
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("to_req",  32'(imem_req),  32'd1);
         chk("to_addr", imem_addr,      32'h48);
         tick();
      end
      chk("to_err",   32'(fetch_err),   32'd1);
      chk("to_req0",  32'(imem_req),    32'd0);
      chk("to_valid", 32'(instr_valid), 32'd0);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("err_hold_req",   32'(imem_req),    32'd0);
      chk("err_hold_valid", 32'(instr_valid), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("err_rd_req",  32'(imem_req),  32'd1);
      chk("err_rd_addr", imem_addr,      32'h100);
      chk("err_sticky",  32'(fetch_err), 32'd1);

      // Reset in FETCH with same-cycle ack
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
      #1;
      chk("mrst_req", 32'(imem_req), 32'd0);
      tick();
      rst = 1'b0; imem_ack = 1'b0;
      #1;
      chk("mrst_valid", 32'(instr_valid), 32'd0);
      chk("mrst_addr",  imem_addr,        32'd0);
      chk("mrst_pcout", pc_out,           32'd0);
      chk("mrst_instr", instr,            32'd0);
      chk("mrst_err",   32'(fetch_err),   32'd0);
`ifdef FETCH_PERF_EN
      chk("mrst_cnt",   fetch_count,      32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
